// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_to_bin_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

endpackage

// File: rtl/bcd_to_bin_seq_digit_mac.sv
// One MSD-first conversion step: acc*10 + digit, plus an out-of-range digit flag.
module bcd_digit_mac
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic [BIN_W-1:0] acc_in,
  input  logic [3:0]       digit,
  output logic [BIN_W-1:0] acc_out,
  output logic             digit_err
);

  // x10 built from shifts; the sum wraps modulo 2^BIN_W by construction
  always_comb begin
    acc_out   = (acc_in << 3) + (acc_in << 1) + BIN_W'(digit);
    digit_err = (digit > BCD_DIGIT_MAX);
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Converts a packed BCD word to binary one digit per clock, with valid/ready
// handshakes on both sides and no overlap between words.
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  state_t                state_q, state_d;
  logic [4*DIGITS-1:0]   shreg_q, shreg_d;
  logic [BIN_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_int_q, err_int_d;
  logic [BIN_W-1:0]      bin_out_q, bin_out_d;
  logic                  err_q, err_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;

  logic [BIN_W-1:0]      mac_acc;
  logic                  mac_err;

  bcd_digit_mac #(.BIN_W(BIN_W)) u_mac (
    .acc_in    (acc_q),
    .digit     (shreg_q[4*DIGITS-1 -: 4]),
    .acc_out   (mac_acc),
    .digit_err (mac_err)
  );

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    err_int_d   = err_int_q;
    bin_out_d   = bin_out_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shreg_d    = bcd_in;
          acc_d      = '0;
          cnt_d      = '0;
          err_int_d  = 1'b0;
          in_ready_d = 1'b0;
          state_d    = ST_CONV;
        end
      end
      ST_CONV: begin
        acc_d     = mac_acc;
        err_int_d = err_int_q | mac_err;
        shreg_d   = shreg_q << 4;
        cnt_d     = cnt_q + CNT_W'(1);
        // Final digit: publish the freshly computed values, not the stale regs
        if (cnt_q == CNT_LAST) begin
          bin_out_d   = mac_acc;
          err_d       = err_int_q | mac_err;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_int_q   <= 1'b0;
      bin_out_q   <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_int_q   <= err_int_d;
      bin_out_q   <= bin_out_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bin_out   = bin_out_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: conversions, error flag, back-pressure,
// busy-input rejection and mid-conversion reset.
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int MAX_WAIT = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       bcd_in;
  logic              out_valid;
  logic              out_ready;
  logic [BIN_W-1:0]  bin_out;
  logic              err;

  int checkCount = 0;
  int passCount  = 0;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until out_valid rises; a timeout returns MAX_WAIT
  task automatic waitValid(output int lat);
    lat = 0;
    while (lat < MAX_WAIT) begin
      tick();
      lat++;
      if (out_valid) break;
    end
  endtask

  // Presents one word for a single accept edge, then waits for the result
  task automatic applyStimulus(input logic [15:0] word, input string tag);
    int lat;
    checkOutput({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
    bcd_in   = word;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    waitValid(lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
  endtask

  task automatic convertWord(input logic [15:0] word, input int expBin, input logic expErr, input string tag);
    out_ready = 1'b1;
    applyStimulus(word, tag);
    checkOutput({tag, "_bin"}, 32'(bin_out), 32'(expBin));
    checkOutput({tag, "_err"}, 32'(err), 32'(expErr));
    tick();
    checkOutput({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    bcd_in    = '0;
    out_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_bin_out", 32'(bin_out), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    convertWord(16'h1234, 1234, 1'b0, "w1234");
    convertWord(16'h9999, 9999, 1'b0, "w9999");
    convertWord(16'h0000, 0,    1'b0, "w0000");
    convertWord(16'h0015, 15,   1'b0, "w0015");
    convertWord(16'h000F, 15,   1'b1, "w000F");
    convertWord(16'hA000, 10000, 1'b1, "wA000");

    // Back-pressure: result and in_ready must hold while out_ready is low
    out_ready = 1'b0;
    applyStimulus(16'h0042, "bp");
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("bp_valid_hold", 32'(out_valid), 32'd1);
      checkOutput("bp_bin_hold", 32'(bin_out), 32'd42);
      checkOutput("bp_in_ready_hold", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    checkOutput("bp_in_ready_release", 32'(in_ready), 32'd1);
    checkOutput("bp_valid_release", 32'(out_valid), 32'd0);

    // Busy rejection: second word held on the input through CONV and DONE
    out_ready = 1'b0;
    bcd_in    = 16'h0100;
    in_valid  = 1'b1;
    tick();
    bcd_in = 16'h0777;
    waitValid(lat);
    checkOutput("busy_latency", 32'(lat), 32'd4);
    checkOutput("busy_first_bin", 32'(bin_out), 32'd100);
    tick();
    tick();
    checkOutput("busy_done_in_ready", 32'(in_ready), 32'd0);
    checkOutput("busy_done_bin", 32'(bin_out), 32'd100);
    out_ready = 1'b1;
    tick();
    checkOutput("busy_idle_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    checkOutput("busy_second_accept", 32'(in_ready), 32'd0);
    waitValid(lat);
    checkOutput("busy_second_latency", 32'(lat), 32'd4);
    checkOutput("busy_second_bin", 32'(bin_out), 32'd777);
    checkOutput("busy_second_err", 32'(err), 32'd0);
    tick();

    // Reset in the middle of a conversion with a bad digit pending
    bcd_in   = 16'hF234;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_err", 32'(err), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("midrst_no_result", 32'(out_valid), 32'd0);
    end
    convertWord(16'h0005, 5, 1'b0, "w0005");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
